// File: rtl/byte_window_buffer.sv
// 16-entry circular byte buffer feeding a 16-to-1 byte mux: the whole register file is exposed flat, rd_sel picks the head.
// Optional BUF_LEVEL_EN adds the level and almost_full outputs for fill-threshold logic.
module byte_window_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic [16*WIDTH-1:0]   data_flat,
  output logic [3:0]            rd_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  full,
`ifdef BUF_LEVEL_EN
  output logic [4:0]            level,
  output logic                  almost_full,
`endif
  output logic                  empty
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [3:0]       wr_ptr_reg;
  logic [3:0]       rd_ptr_reg;
  logic [4:0]       count_reg;
  logic             push;
  logic             pop;

  // Flags decode only the registered count, so no input reaches an output combinationally.
  assign full      = (count_reg == 5'd16);
  assign empty     = (count_reg == 5'd0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign rd_sel    = rd_ptr_reg;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

`ifdef BUF_LEVEL_EN
  assign level       = count_reg;
  assign almost_full = (count_reg >= 5'd14);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign data_flat[WIDTH*gi +: WIDTH] = mem_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= 4'd0;
      rd_ptr_reg <= 4'd0;
      count_reg  <= 5'd0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= in_data;
        wr_ptr_reg          <= wr_ptr_reg + 4'd1;
      end
      // Popped entries are left in place; stale bytes stay visible on data_flat.
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 4'd1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 5'd1;
        2'b01:   count_reg <= count_reg - 5'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: doc/byte_window_buffer.md
Name: byte_window_buffer

Overview:
- 16-entry circular byte buffer that sits directly upstream of the 16-to-1 byte mux.
- Accepts a byte stream over a valid/ready handshake and stores it in a register file.
- Exposes the register file as a flat 128-bit bus, plus a 4-bit head pointer that drives the mux select.
- The downstream datapath pops one byte per handshake.

Parameters:
- WIDTH, 8, bits per entry. The flat bus width is 16*WIDTH. The default 8 matches the 128-bit mux input.
- DEPTH, 16, number of entries. It is fixed at 16 because the select is 4 bits. No other value is supported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a byte on in_data.
- in_data  input  WIDTH  byte to store.
- in_ready  output  1  buffer can accept a byte. Equal to !full.
- data_flat  output  16*WIDTH  entry i on bits [WIDTH*i+WIDTH-1 : WIDTH*i].
- rd_sel  output  4  head (oldest entry) index. Drives the mux select.
- out_valid  output  1  head entry holds valid data. Equal to !empty.
- out_ready  input  1  consumer takes the head entry this cycle.
- full  output  1  count == 16.
- empty  output  1  count == 0.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - All entries go to 0; data_flat = 0.
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - Outputs after reset: rd_sel = 0, empty = 1, full = 0, in_ready = 1, out_valid = 0.
  - Reset has priority over push and pop in the same cycle. A reset mid-stream discards all contents.
- Push: in_valid && in_ready at a rising edge.
  - mem[wr_ptr] <= in_data.
  - wr_ptr <= wr_ptr + 1, wrapping 15 -> 0 as a 4-bit modulo.
- Pop: out_valid && out_ready at a rising edge.
  - rd_ptr <= rd_ptr + 1, wrapping 15 -> 0.
  - The entry is not cleared; stale bytes stay visible on data_flat.
- count is a 5-bit register, range 0..16:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers advance.
- Full: in_ready = 0 and the push is ignored. A same-cycle pop still happens. There is no bypass, so the byte is accepted on the next cycle.
- Empty: out_valid = 0 and out_ready is ignored; rd_ptr holds. A same-cycle push is accepted and out_valid rises on the next cycle. There is no fall-through.
- in_ready, out_valid, full and empty are combinational decodes of the registered count only. They have no combinational path from in_valid or out_ready.
- rd_sel = rd_ptr, registered. The mux output is valid in the same cycle as out_valid, so head-data latency is zero.
- Write-to-visible latency: a byte pushed at edge N appears on data_flat after edge N. If the buffer was empty, out_valid = 1 after edge N.
- in_valid while full: the byte is silently dropped by the handshake. The producer must hold it until in_ready.
- No X propagation: every register has a reset value.

Optional Feature:
- Macro: BUF_LEVEL_EN.
- Defined:
  - Adds output level [4:0], equal to the registered count (0..16), for the controller's fill-threshold logic.
  - Adds output almost_full, equal to (count >= 14).
  - Both read 0 during and after reset.
- Undefined: neither port exists. All other behaviour is identical.

Test Plan:
- Reset then idle: assert rst for 2 cycles -> data_flat = 0, rd_sel = 0, empty = 1, in_ready = 1, out_valid = 0.
- Fill: push 0x10..0x1F on 16 consecutive cycles with out_ready = 0 -> full = 1, in_ready = 0, data_flat = 128'h1F1E...1110. A 17th push of 0xAA is ignored and data_flat is unchanged.
- Drain with wrap: from full, pop 16 times -> rd_sel steps 0..15 then wraps to 0, the mux output at each step is 0x10+i, and empty = 1 at the end.
- Simultaneous push/pop:
  - At count 5: push 0x55 and pop together -> count stays 5 and both pointers advance.
  - At full: push blocked, pop occurs, and count goes 16 -> 15.
- Empty plus push/pop: with empty = 1, push 0x77 and assert out_ready -> rd_sel stays 0; next cycle out_valid = 1 and the mux output = 0x77.
- Reset mid-operation: at count 9, assert rst together with in_valid and out_ready -> next cycle count = 0, data_flat = 0, rd_sel = 0. With BUF_LEVEL_EN, level = 0 and almost_full = 0.
